ps2_frame_rx: RTL

PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

---
 rtl/ps2_frame_rx_pkg.sv | 20 ++
 rtl/ps2_line_filter.sv | 46 ++++
 rtl/ps2_frame_rx.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ps2_frame_rx_pkg.sv
// Shared PS/2 frame definitions: frame geometry, FSM state encodings and
// the odd-parity helper. Scan-code names live separately in keycodes.vh.
package ps2_frame_rx_pkg;

    localparam int PS2_DATA_BITS = 8;
    localparam int PS2_BITCNT_W  = 3;

    // Receive FSM encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // A frame is good when data plus parity carries an odd number of ones.
    function automatic logic ps2_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                           input logic                     par);
        return ^{par, data};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a glitch filter for a PS/2 line.
// The filtered level follows the synchronized input only after FILTER_LEN
// consecutive samples disagree with the current filtered level.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic level
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] run_cnt;

    // Bring the asynchronous line into the clk domain; idle bus level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= line;
            sync_2 <= sync_1;
        end
    end

    // Count the run of samples that disagree with the filtered level; flip on a full run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt <= '0;
            level   <= 1'b1;
        end else if (sync_2 == level) begin
            run_cnt <= '0;
        end else if (run_cnt == CNT_LAST) begin
            run_cnt <= '0;
            level   <= sync_2;
        end else begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd
// parity, stop. Good frames update ps2_key_code; bad ones raise a one-cycle
// error pulse. A watchdog abandons frames whose clock stalls.
//
//   state  | meaning
//   IDLE   | waiting for a start bit (data low on a clock fall)
//   DATA   | shifting in the 8 data bits
//   PARITY | capturing the parity bit
//   STOP   | checking the stop bit and parity, then reporting
module ps2_frame_rx
    import ps2_frame_rx_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 2048
) (
    input  logic       clk256,
    input  logic       reset,
    inout  wire        PS2C,
    inout  wire        PS2D,
    output logic [7:0] ps2_key_code,
    output logic       code_strobe,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]         WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [PS2_BITCNT_W-1:0] BIT_LAST = PS2_BITCNT_W'(PS2_DATA_BITS - 1);

    logic                      clk_filt;
    logic                      clk_prev;
    logic                      data_s1;
    logic                      data_s2;
    logic                      bit_ev;
    logic                      wd_expire;
    logic [1:0]                state;
    logic [PS2_BITCNT_W-1:0]   bit_cnt;
    logic [PS2_DATA_BITS-1:0]  data_sr;
    logic                      par_bit;
    logic [WD_W-1:0]           wd_cnt;

    // PS2C and PS2D are only ever observed; the device owns both lines.
    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk   (clk256),
        .rst   (reset),
        .line  (PS2C),
        .level (clk_filt)
    );

    // Synchronize PS2D and remember the previous filtered clock for edge detection.
    always_ff @(posedge clk256 or posedge reset) begin
        if (reset) begin
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
            clk_prev <= 1'b1;
        end else begin
            data_s1  <= PS2D;
            data_s2  <= data_s1;
            clk_prev <= clk_filt;
        end
    end

    assign bit_ev    = clk_prev & ~clk_filt;
    assign wd_expire = (state != ST_IDLE) && !bit_ev && (wd_cnt == WD_LAST);

    // Watchdog: cycles since the last bit event while a frame is in progress.
    always_ff @(posedge clk256 or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state == ST_IDLE || bit_ev || wd_expire) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Frame FSM with shift register and registered result pulses.
    always_ff @(posedge clk256 or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            data_sr      <= '0;
            par_bit      <= 1'b0;
            ps2_key_code <= 8'h00;
            code_strobe  <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            code_strobe <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            if (wd_expire) begin
                frame_err <= 1'b1;
                state     <= ST_IDLE;
            end else if (bit_ev) begin
                case (state)
                    ST_IDLE: begin
                        if (!data_s2) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        data_sr <= {data_s2, data_sr[PS2_DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_bit <= data_s2;
                        state   <= ST_STOP;
                    end
                    default: begin
                        // A bad stop bit outranks a parity error.
                        if (!data_s2) begin
                            frame_err <= 1'b1;
                        end else if (ps2_parity_ok(data_sr, par_bit)) begin
                            ps2_key_code <= data_sr;
                            code_strobe  <= 1'b1;
                        end else begin
                            parity_err <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
